// File: rtl/strength_pkg.sv
// Shared types for strength-annotated net resolution: strength codes, 4-state
// value encoding, keeper states and a strength comparator.
package strength_pkg;

    typedef enum logic [2:0] {
        ST_HIGHZ  = 3'd0,
        ST_SMALL  = 3'd1,
        ST_MEDIUM = 3'd2,
        ST_WEAK   = 3'd3,
        ST_LARGE  = 3'd4,
        ST_PULL   = 3'd5,
        ST_STRONG = 3'd6,
        ST_SUPPLY = 3'd7
    } strength_e;

    typedef enum logic [1:0] {
        L4_0 = 2'b00,
        L4_1 = 2'b01,
        L4_X = 2'b10,
        L4_Z = 2'b11
    } logic4_e;

    typedef enum logic [1:0] {
        FLOAT   = 2'd0,
        DRIVEN  = 2'd1,
        HELD    = 2'd2,
        DECAYED = 2'd3
    } keeper_state_e;

    localparam logic [1:0] LOGIC4_Z = L4_Z;

    function automatic logic [2:0] str_max(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/strength_max_tree.sv
// Combinational reduction of all drivers to the strongest 0 and strongest 1
// contribution; a strength of highz never wins.
module strength_max_tree
    import strength_pkg::*;
#(
    parameter int N_DRV = 2
) (
    input  logic [N_DRV-1:0]   drv_val,
    input  logic [3*N_DRV-1:0] drv_str0,
    input  logic [3*N_DRV-1:0] drv_str1,
    output logic [2:0]         s0,
    output logic [2:0]         s1
);

    always_comb begin
        s0 = ST_HIGHZ;
        s1 = ST_HIGHZ;
        for (int i = 0; i < N_DRV; i++) begin
            if (drv_val[i])
                s1 = str_max(s1, drv_str1[3*i +: 3]);
            else
                s0 = str_max(s0, drv_str0[3*i +: 3]);
        end
    end

endmodule

// File: rtl/strength_net_resolver.sv
// Resolves N strength-annotated drivers into a registered 4-state net value,
// with optional trireg-style charge keeping/decay and a contention counter.
//
// state   | meaning
// FLOAT   | undriven, no charge: z at strength 0
// DRIVEN  | at least one driver active: resolved value/strength
// HELD    | undriven, charge retained: held value at CHARGE_STR
// DECAYED | charge leaked away: x at CHARGE_STR
module strength_net_resolver
    import strength_pkg::*;
#(
    parameter int N_DRV        = 2,
    parameter int KEEPER       = 0,
    parameter int DECAY_CYCLES = 0,
    parameter int CHARGE_STR   = 2,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_DRV-1:0]   drv_val,
    input  logic [3*N_DRV-1:0] drv_str0,
    input  logic [3*N_DRV-1:0] drv_str1,
    output logic [1:0]         net_val,
    output logic [2:0]         net_str,
    output logic               contention,
    output logic [CNT_W-1:0]   cont_cnt,
    output logic [1:0]         state_o
);

    localparam int DCNT_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES + 1) : 1;
    localparam logic [2:0] CHG_STR = 3'(CHARGE_STR);

    logic [2:0]        s0, s1;
    logic              undriven, cont;
    logic [1:0]        res_val;
    logic [2:0]        res_str;

    keeper_state_e     state, state_nxt;
    logic [1:0]        hold_val, hold_nxt;
    logic [DCNT_W-1:0] dcnt, dcnt_nxt;
    logic [1:0]        val_nxt;
    logic [2:0]        str_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

    strength_max_tree #(.N_DRV(N_DRV)) u_tree (
        .drv_val  (drv_val),
        .drv_str0 (drv_str0),
        .drv_str1 (drv_str1),
        .s0       (s0),
        .s1       (s1)
    );

    // Equal nonzero strengths are the only way to get x from live drivers.
    always_comb begin
        undriven = (s0 == ST_HIGHZ) && (s1 == ST_HIGHZ);
        cont     = !undriven && (s0 == s1);
        res_val  = L4_X;
        res_str  = s1;
        if (s1 > s0) begin
            res_val = L4_1;
            res_str = s1;
        end else if (s0 > s1) begin
            res_val = L4_0;
            res_str = s0;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_val;
        dcnt_nxt  = dcnt;
        val_nxt   = LOGIC4_Z;
        str_nxt   = ST_HIGHZ;
        if (!undriven) begin
            state_nxt = DRIVEN;
            val_nxt   = res_val;
            str_nxt   = res_str;
            dcnt_nxt  = '0;
        end else begin
            case (state)
                FLOAT: begin
                    state_nxt = FLOAT;
                end
                DRIVEN: begin
                    if (KEEPER != 0) begin
                        // The registered output is the last resolved value.
                        state_nxt = HELD;
                        hold_nxt  = net_val;
                        dcnt_nxt  = DCNT_W'(DECAY_CYCLES);
                        val_nxt   = net_val;
                        str_nxt   = CHG_STR;
                    end else begin
                        state_nxt = FLOAT;
                    end
                end
                HELD: begin
                    val_nxt = hold_val;
                    str_nxt = CHG_STR;
                    if (DECAY_CYCLES != 0) begin
                        if (dcnt <= DCNT_W'(1)) begin
                            state_nxt = DECAYED;
                            dcnt_nxt  = '0;
                            val_nxt   = L4_X;
                        end else begin
                            dcnt_nxt = dcnt - DCNT_W'(1);
                        end
                    end
                end
                DECAYED: begin
                    val_nxt = L4_X;
                    str_nxt = CHG_STR;
                end
                default: begin
                    state_nxt = FLOAT;
                end
            endcase
        end
    end

    always_comb begin
        cnt_nxt = cont_cnt;
        if (cont && (cont_cnt != {CNT_W{1'b1}}))
            cnt_nxt = cont_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FLOAT;
            hold_val   <= LOGIC4_Z;
            dcnt       <= '0;
            net_val    <= LOGIC4_Z;
            net_str    <= ST_HIGHZ;
            contention <= 1'b0;
            cont_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            hold_val   <= hold_nxt;
            dcnt       <= dcnt_nxt;
            net_val    <= val_nxt;
            net_str    <= str_nxt;
            contention <= cont;
            cont_cnt   <= cnt_nxt;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_strength_net_resolver.sv
// Directed bench: four resolver configurations share one stimulus stream and
// are checked against hand-computed expectations.
module tb_strength_net_resolver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] drv_val;
    logic [5:0] drv_str0, drv_str1;

    int checks = 0;
    int errors = 0;

    logic [1:0] w_val, k_val, d_val, s_val;
    logic [2:0] w_str, k_str, d_str, s_str;
    logic       w_cont, k_cont, d_cont, s_cont;
    logic [15:0] w_cnt, k_cnt, d_cnt;
    logic [3:0]  s_cnt;
    logic [1:0] w_st, k_st, d_st, s_st;

    always #5 clk = ~clk;

    // plain wire
    strength_net_resolver #(.N_DRV(2), .KEEPER(0), .DECAY_CYCLES(0), .CHARGE_STR(2), .CNT_W(16)) dut_w (
        .clk(clk), .rst(rst), .drv_val(drv_val), .drv_str0(drv_str0), .drv_str1(drv_str1),
        .net_val(w_val), .net_str(w_str), .contention(w_cont), .cont_cnt(w_cnt), .state_o(w_st));
    // keeper with 3-cycle decay
    strength_net_resolver #(.N_DRV(2), .KEEPER(1), .DECAY_CYCLES(3), .CHARGE_STR(2), .CNT_W(16)) dut_k (
        .clk(clk), .rst(rst), .drv_val(drv_val), .drv_str0(drv_str0), .drv_str1(drv_str1),
        .net_val(k_val), .net_str(k_str), .contention(k_cont), .cont_cnt(k_cnt), .state_o(k_st));
    // keeper that never decays
    strength_net_resolver #(.N_DRV(2), .KEEPER(1), .DECAY_CYCLES(0), .CHARGE_STR(4), .CNT_W(16)) dut_d (
        .clk(clk), .rst(rst), .drv_val(drv_val), .drv_str0(drv_str0), .drv_str1(drv_str1),
        .net_val(d_val), .net_str(d_str), .contention(d_cont), .cont_cnt(d_cnt), .state_o(d_st));
    // narrow counter for saturation
    strength_net_resolver #(.N_DRV(2), .KEEPER(0), .DECAY_CYCLES(0), .CHARGE_STR(2), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .drv_val(drv_val), .drv_str0(drv_str0), .drv_str1(drv_str1),
        .net_val(s_val), .net_str(s_str), .contention(s_cont), .cont_cnt(s_cnt), .state_o(s_st));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        drv_val  = 2'b00;
        drv_str0 = 6'd0;
        drv_str1 = 6'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        release_all();
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({w_val, w_str, w_cont, w_st} !== 8'b11_000_0_00 || w_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_w: got val=%b str=%0d cont=%b st=%0d cnt=%0d want val=11 str=0 cont=0 st=0 cnt=0", w_val, w_str, w_cont, w_st, w_cnt);
        end
        checks++;
        if ({k_val, k_str, k_cont, k_st} !== 8'b11_000_0_00 || k_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_k: got val=%b str=%0d cont=%b st=%0d cnt=%0d want val=11 str=0 cont=0 st=0 cnt=0", k_val, k_str, k_cont, k_st, k_cnt);
        end
        checks++;
        if ({s_val, s_str, s_cont, s_st} !== 8'b11_000_0_00 || s_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_s: got val=%b str=%0d cont=%b st=%0d cnt=%0d want val=11 str=0 cont=0 st=0 cnt=0", s_val, s_str, s_cont, s_st, s_cnt);
        end
    endtask

    task automatic test_undriven();
        // both drive 1 at highz: the str0 field must be ignored
        drv_val  = 2'b11;
        drv_str0 = {3'd3, 3'd3};
        drv_str1 = {3'd0, 3'd0};
        step();
        checks++;
        if ({w_val, w_str, w_cont, w_st} !== 8'b11_000_0_00) begin
            errors++;
            $display("FAIL undriven_w: got val=%b str=%0d cont=%b st=%0d want val=11 str=0 cont=0 st=0", w_val, w_str, w_cont, w_st);
        end
        checks++;
        if ({k_val, k_str, k_st} !== 7'b11_000_00) begin
            errors++;
            $display("FAIL undriven_k: got val=%b str=%0d st=%0d want val=11 str=0 st=0", k_val, k_str, k_st);
        end
    endtask

    task automatic test_strong_wins();
        drv_val  = 2'b01;
        drv_str1 = {3'd0, 3'd6};
        drv_str0 = {3'd5, 3'd0};
        step();
        checks++;
        if ({w_val, w_str, w_cont, w_st} !== 8'b01_110_0_01) begin
            errors++;
            $display("FAIL strong_wins: got val=%b str=%0d cont=%b st=%0d want val=01 str=6 cont=0 st=1", w_val, w_str, w_cont, w_st);
        end
        // 0 @ supply beats 1 @ pull
        drv_val  = 2'b01;
        drv_str1 = {3'd0, 3'd5};
        drv_str0 = {3'd7, 3'd0};
        step();
        checks++;
        if ({w_val, w_str, w_cont} !== 6'b00_111_0) begin
            errors++;
            $display("FAIL zero_wins: got val=%b str=%0d cont=%b want val=00 str=7 cont=0", w_val, w_str, w_cont);
        end
    endtask

    task automatic test_contention();
        drv_val  = 2'b01;
        drv_str1 = {3'd0, 3'd3};
        drv_str0 = {3'd3, 3'd0};
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({w_val, w_str, w_cont} !== 6'b10_011_1 || w_cnt !== 16'(i + 1)) begin
                errors++;
                $display("FAIL contention[%0d]: got val=%b str=%0d cont=%b cnt=%0d want val=10 str=3 cont=1 cnt=%0d", i, w_val, w_str, w_cont, w_cnt, i + 1);
            end
        end
    endtask

    task automatic test_keeper_decay();
        // duplicate identical drivers: one 0 @ strong, no contention
        drv_val  = 2'b00;
        drv_str0 = {3'd6, 3'd6};
        drv_str1 = {3'd0, 3'd0};
        step();
        checks++;
        if ({k_val, k_str, k_cont, k_st} !== 8'b00_110_0_01 || k_cnt !== 16'd4) begin
            errors++;
            $display("FAIL duplicate_drv: got val=%b str=%0d cont=%b st=%0d cnt=%0d want val=00 str=6 cont=0 st=1 cnt=4", k_val, k_str, k_cont, k_st, k_cnt);
        end
        release_all();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({k_val, k_str, k_st} !== 7'b00_010_10) begin
                errors++;
                $display("FAIL held[%0d]: got val=%b str=%0d st=%0d want val=00 str=2 st=2", i, k_val, k_str, k_st);
            end
        end
        checks++;
        if ({w_val, w_str, w_st} !== 7'b11_000_00) begin
            errors++;
            $display("FAIL wire_release: got val=%b str=%0d st=%0d want val=11 str=0 st=0", w_val, w_str, w_st);
        end
        step();
        checks++;
        if ({k_val, k_str, k_st} !== 7'b10_010_11) begin
            errors++;
            $display("FAIL decayed: got val=%b str=%0d st=%0d want val=10 str=2 st=3", k_val, k_str, k_st);
        end
        step();
        checks++;
        if ({k_val, k_str, k_st} !== 7'b10_010_11) begin
            errors++;
            $display("FAIL decayed_stay: got val=%b str=%0d st=%0d want val=10 str=2 st=3", k_val, k_str, k_st);
        end
        checks++;
        if ({d_val, d_str, d_st} !== 7'b00_100_10) begin
            errors++;
            $display("FAIL no_decay: got val=%b str=%0d st=%0d want val=00 str=4 st=2", d_val, d_str, d_st);
        end
        drv_val  = 2'b01;
        drv_str1 = {3'd0, 3'd5};
        drv_str0 = {3'd0, 3'd0};
        step();
        checks++;
        if ({k_val, k_str, k_st} !== 7'b01_101_01) begin
            errors++;
            $display("FAIL redrive_k: got val=%b str=%0d st=%0d want val=01 str=5 st=1", k_val, k_str, k_st);
        end
        checks++;
        if ({d_val, d_str, d_st} !== 7'b01_101_01) begin
            errors++;
            $display("FAIL redrive_d: got val=%b str=%0d st=%0d want val=01 str=5 st=1", d_val, d_str, d_st);
        end
    endtask

    task automatic test_reset_mid_hold();
        release_all();
        step();
        checks++;
        if ({k_val, k_str, k_st} !== 7'b01_010_10) begin
            errors++;
            $display("FAIL held_one: got val=%b str=%0d st=%0d want val=01 str=2 st=2", k_val, k_str, k_st);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({k_val, k_str, k_cont, k_st} !== 8'b11_000_0_00 || k_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_hold: got val=%b str=%0d cont=%b st=%0d cnt=%0d want val=11 str=0 cont=0 st=0 cnt=0", k_val, k_str, k_cont, k_st, k_cnt);
        end
        step();
        checks++;
        if ({k_val, k_str, k_st} !== 7'b11_000_00) begin
            errors++;
            $display("FAIL after_reset: got val=%b str=%0d st=%0d want val=11 str=0 st=0", k_val, k_str, k_st);
        end
    endtask

    task automatic test_saturation();
        drv_val  = 2'b10;
        drv_str1 = {3'd7, 3'd0};
        drv_str0 = {3'd0, 3'd7};
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (s_cont !== 1'b1 || s_cnt !== 4'(((i + 1) > 15) ? 15 : (i + 1))) begin
                errors++;
                $display("FAIL saturate[%0d]: got cont=%b cnt=%0d want cont=1 cnt=%0d", i, s_cont, s_cnt, ((i + 1) > 15) ? 15 : (i + 1));
            end
        end
        checks++;
        if (w_cnt !== 16'd20 || w_val !== 2'b10 || w_str !== 3'd7) begin
            errors++;
            $display("FAIL wide_cnt: got cnt=%0d val=%b str=%0d want cnt=20 val=10 str=7", w_cnt, w_val, w_str);
        end
        release_all();
        step();
        checks++;
        if (s_cont !== 1'b0 || s_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: got cont=%b cnt=%0d want cont=0 cnt=15", s_cont, s_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        release_all();
        test_reset();
        test_undriven();
        test_strong_wins();
        test_contention();
        test_keeper_decay();
        test_reset_mid_hold();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
